bmem_port_arbiter: RTL and testbench

BMEM_PORT_ARBITER -- requirements
Module: bmem_port_arbiter

---
 rtl/bmem_port_arbiter_if.sv | 45 ++++
 rtl/bmem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_bmem_port_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bmem_port_arbiter_if.sv
// Signal bundle between the burst memory port, the instruction cache and the data cache.
// The master modport is the arbiter's view; slave is the memory/cache environment.
interface bmem_port_arbiter_if;
    logic        bmem_ready;
    logic        bmem_read;
    logic        bmem_write;
    logic [31:0] bmem_addr;
    logic [63:0] bmem_wdata;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;

    logic        icache_read;
    logic [31:0] icache_addr;
    logic [63:0] icache_rdata;
    logic        icache_rvalid;
    logic        icache_done;

    logic        dcache_read;
    logic        dcache_write;
    logic [31:0] dcache_addr;
    logic [63:0] dcache_wdata;
    logic        dcache_wready;
    logic [63:0] dcache_rdata;
    logic        dcache_rvalid;
    logic        dcache_done;

    modport master (
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  icache_read, icache_addr,
        input  dcache_read, dcache_write, dcache_addr, dcache_wdata,
        output bmem_read, bmem_write, bmem_addr, bmem_wdata,
        output icache_rdata, icache_rvalid, icache_done,
        output dcache_wready, dcache_rdata, dcache_rvalid, dcache_done
    );

    modport slave (
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        output icache_read, icache_addr,
        output dcache_read, dcache_write, dcache_addr, dcache_wdata,
        input  bmem_read, bmem_write, bmem_addr, bmem_wdata,
        input  icache_rdata, icache_rvalid, icache_done,
        input  dcache_wready, dcache_rdata, dcache_rvalid, dcache_done
    );
endinterface

// File: rtl/bmem_port_arbiter.sv
// Shares one burst memory port between icache (line reads) and dcache (line reads/writes),
// one transaction at a time, alternating owners under contention so neither starves.
module bmem_port_arbiter #(
    parameter int unsigned BURST_LEN = 4
) (
    input logic               clk,
    input logic               rst,
    bmem_port_arbiter_if.master io
);
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(32'h1F);

    typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR_BURST, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  beat;
    logic              own_d;
    logic              icache_first;
    logic [ADDR_W-1:0] addr_q;
    logic              read_q;
    logic              write_q;
    logic              done_i_q;
    logic              done_d_q;

    logic d_req;
    logic grant_d;
    logic run;
    logic fwd;

    // icache jumps the queue only right after a dcache line that kept it waiting
    always_comb begin
        d_req   = io.dcache_read || io.dcache_write;
        grant_d = d_req && !(icache_first && io.icache_read);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            beat         <= '0;
            own_d        <= 1'b0;
            icache_first <= 1'b0;
            addr_q       <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            done_i_q     <= 1'b0;
            done_d_q     <= 1'b0;
        end else begin
            done_i_q <= 1'b0;
            done_d_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_req || io.icache_read) begin
                        own_d  <= grant_d;
                        beat   <= '0;
                        addr_q <= (grant_d ? io.dcache_addr : io.icache_addr) & LINE_MASK;
                        if (grant_d && io.dcache_write) begin
                            state   <= WR_BURST;
                            write_q <= 1'b1;
                        end else begin
                            state   <= RD_CMD;
                            read_q  <= 1'b1;
                        end
                    end
                end
                RD_CMD: begin
                    if (io.bmem_ready) begin
                        state  <= RD_WAIT;
                        read_q <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (io.bmem_rvalid) begin
                        beat <= beat + CNT_W'(1);
                        if (beat == LAST_BEAT) begin
                            state    <= DONE;
                            done_i_q <= !own_d;
                            done_d_q <= own_d;
                        end
                    end
                end
                WR_BURST: begin
                    if (io.bmem_ready) begin
                        beat <= beat + CNT_W'(1);
                        if (beat == LAST_BEAT) begin
                            state    <= DONE;
                            write_q  <= 1'b0;
                            done_i_q <= !own_d;
                            done_d_q <= own_d;
                        end
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    icache_first <= own_d && io.icache_read;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Every output is forced low while reset is applied, even mid-burst
    always_comb begin
        run              = !rst;
        fwd              = run && (state == RD_WAIT) && io.bmem_rvalid;
        io.bmem_read     = run && read_q;
        io.bmem_write    = run && write_q;
        io.bmem_addr     = (run && (read_q || write_q)) ? addr_q : '0;
        io.bmem_wdata    = (run && write_q) ? io.dcache_wdata : '0;
        io.dcache_wready = run && write_q && io.bmem_ready;
        io.icache_rvalid = fwd && !own_d;
        io.dcache_rvalid = fwd && own_d;
        io.icache_rdata  = (fwd && !own_d) ? io.bmem_rdata : DATA_W'(0);
        io.dcache_rdata  = (fwd && own_d) ? io.bmem_rdata : DATA_W'(0);
        io.icache_done   = run && done_i_q;
        io.dcache_done   = run && done_d_q;
    end

    a_no_rw_overlap: assert property (@(posedge clk) disable iff (rst)
        !(io.bmem_read && io.bmem_write));
    a_raddr_match: assert property (@(posedge clk) disable iff (rst)
        (state == RD_WAIT && io.bmem_rvalid) |-> (io.bmem_raddr == addr_q));
endmodule

// File: tb/tb_bmem_port_arbiter.sv
// Randomized scoreboard bench for bmem_port_arbiter: a memory responder, two cache drivers,
// a transaction-order reference model and a monitor that checks every beat and done pulse.
module tb_bmem_port_arbiter;
    localparam int BL = 4;
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

    typedef struct packed {
        logic        own_d;
        logic        wr;
        logic [31:0] line;
    } txn_t;

    logic clk;
    logic rst;
    bmem_port_arbiter_if bus();

    bmem_port_arbiter #(.BURST_LEN(BL)) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    int   total = 0;
    int   passed = 0;
    int   cyc = 0;
    txn_t exp_q[$];
    txn_t cur;
    logic cur_v = 1'b0;
    int   beats = 0;
    logic rd_acc = 1'b0;
    logic prev_cmd = 1'b0;
    int   last_cyc = 0;
    int   rd_cycles = 0;
    int   wr_cycles = 0;
    int   wready_cnt = 0;

    logic        ready_rand = 1'b0;
    logic        rv_always = 1'b1;
    logic        spur_en = 1'b0;
    logic        arm_pat = 1'b0;
    logic        ready_pat[$];
    logic [31:0] i_addrs[$];
    logic [31:0] d_addrs[$];
    int          d_ops[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    function automatic logic [63:0] mem_word(input logic [31:0] line, input int b);
        if (line == 32'h0000_1220) return 64'(10 + b);
        return {line ^ 32'h5A5A_0000, 32'hC0DE_0000 + 32'(b)};
    endfunction

    function automatic logic [63:0] wd(input logic [31:0] line, input int b);
        return {~line, 32'h0000_7700 + 32'(b)};
    endfunction

    function automatic logic any_out();
        return bus.bmem_read | bus.bmem_write | (|bus.bmem_addr) | (|bus.bmem_wdata)
             | bus.icache_rvalid | (|bus.icache_rdata) | bus.icache_done
             | bus.dcache_wready | (|bus.dcache_rdata) | bus.dcache_rvalid | bus.dcache_done;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: actual=%0h required=%0h", nm, cyc, act, exp);
    endtask

    // Memory responder: accepts read commands, returns BL beats, optionally injects stray rvalid
    initial begin
        logic        rd_active;
        logic [31:0] rd_line;
        int          sent;
        rd_active = 1'b0;
        rd_line = '0;
        sent = 0;
        bus.bmem_ready = 1'b1;
        bus.bmem_rvalid = 1'b0;
        bus.bmem_rdata = '0;
        bus.bmem_raddr = '0;
        forever begin
            @(negedge clk);
            if (rst) rd_active = 1'b0;
            else if (bus.bmem_read && bus.bmem_ready && !rd_active) begin
                rd_active = 1'b1;
                rd_line = bus.bmem_addr;
                sent = 0;
            end
            if (arm_pat && bus.dcache_write) begin
                ready_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
                arm_pat = 1'b0;
            end
            @(posedge clk);
            #1;
            if (ready_pat.size() != 0) bus.bmem_ready = ready_pat.pop_front();
            else if (ready_rand) bus.bmem_ready = ($urandom_range(0, 3) != 0);
            else bus.bmem_ready = 1'b1;
            if (rd_active && (rv_always || $urandom_range(0, 2) != 0)) begin
                bus.bmem_rvalid = 1'b1;
                bus.bmem_rdata = mem_word(rd_line, sent);
                bus.bmem_raddr = rd_line;
                sent++;
                if (sent == BL) rd_active = 1'b0;
            end else if (spur_en && !rd_active && $urandom_range(0, 2) == 0) begin
                bus.bmem_rvalid = 1'b1;
                bus.bmem_rdata = {$urandom, $urandom};
                bus.bmem_raddr = $urandom;
            end else begin
                bus.bmem_rvalid = 1'b0;
            end
        end
    end

    // Monitor: pops the expected transaction when a command appears and checks it to completion
    initial begin
        logic cmd;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                cur_v = 1'b0;
                prev_cmd = 1'b0;
                beats = 0;
                rd_acc = 1'b0;
                continue;
            end
            cmd = bus.bmem_read | bus.bmem_write;
            if (bus.bmem_read) rd_cycles++;
            if (bus.bmem_write) wr_cycles++;
            if (bus.dcache_wready) wready_cnt++;
            if (cmd && !prev_cmd) begin
                if (exp_q.size() == 0) chk("unexpected_cmd", 64'(1), 64'(0));
                else begin
                    cur = exp_q.pop_front();
                    cur_v = 1'b1;
                    beats = 0;
                    rd_acc = 1'b0;
                    chk("cmd_is_write", 64'(bus.bmem_write), 64'(cur.wr));
                    chk("cmd_addr", 64'(bus.bmem_addr), 64'(cur.line));
                end
            end
            if (bus.bmem_read && bus.bmem_write) chk("rd_wr_exclusive", 64'(1), 64'(0));
            if (!cur_v) chk("idle_addr_wdata", 64'(|{bus.bmem_addr, bus.bmem_wdata}), 64'(0));
            if (bus.icache_rvalid || bus.dcache_rvalid) begin
                if (!(cur_v && !cur.wr && rd_acc && beats < BL))
                    chk("spurious_rvalid", 64'(1), 64'(0));
                else begin
                    chk("rvalid_owner", 64'({bus.icache_rvalid, bus.dcache_rvalid}),
                        64'(cur.own_d ? 2'b01 : 2'b10));
                    chk("rdata", cur.own_d ? bus.dcache_rdata : bus.icache_rdata,
                        mem_word(cur.line, beats));
                    beats++;
                    last_cyc = cyc;
                end
            end
            if (bus.bmem_read && bus.bmem_ready) rd_acc = 1'b1;
            if (bus.bmem_write || bus.dcache_wready)
                chk("wready", 64'(bus.dcache_wready), 64'(bus.bmem_write & bus.bmem_ready));
            if (bus.bmem_write && bus.bmem_ready && cur_v) begin
                chk("wdata", bus.bmem_wdata, wd(cur.line, beats));
                beats++;
                last_cyc = cyc;
            end
            if (bus.icache_done || bus.dcache_done) begin
                if (!cur_v) chk("unexpected_done", 64'(1), 64'(0));
                else begin
                    chk("done_owner", 64'({bus.icache_done, bus.dcache_done}),
                        64'(cur.own_d ? 2'b01 : 2'b10));
                    chk("done_beats", 64'(beats), 64'(BL));
                    chk("done_latency", 64'(cyc - last_cyc), 64'(1));
                    cur_v = 1'b0;
                end
            end
            prev_cmd = cmd;
        end
    end

    task automatic icache_drv(input int n);
        for (int k = 0; k < n; k++) begin
            int t;
            @(posedge clk);
            #1;
            bus.icache_read = 1'b1;
            bus.icache_addr = i_addrs[k];
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus.icache_done && t < 400);
            if (!bus.icache_done) chk("icache_done_timeout", 64'(0), 64'(1));
        end
        @(posedge clk);
        #1;
        bus.icache_read = 1'b0;
    endtask

    task automatic dcache_drv(input int n);
        for (int k = 0; k < n; k++) begin
            int t;
            int wbeat;
            logic [31:0] line;
            line = d_addrs[k] & LINE_MASK;
            @(posedge clk);
            #1;
            bus.dcache_read = (d_ops[k] != 1);
            bus.dcache_write = (d_ops[k] != 0);
            bus.dcache_addr = d_addrs[k];
            wbeat = 0;
            bus.dcache_wdata = wd(line, 0);
            t = 0;
            forever begin
                @(negedge clk);
                t++;
                if (bus.dcache_done) break;
                if (t > 400) begin
                    chk("dcache_done_timeout", 64'(0), 64'(1));
                    break;
                end
                if (bus.dcache_wready) begin
                    wbeat++;
                    @(posedge clk);
                    #1;
                    bus.dcache_wdata = wd(line, wbeat);
                end
            end
        end
        @(posedge clk);
        #1;
        bus.dcache_read = 1'b0;
        bus.dcache_write = 1'b0;
    endtask

    // Reference order: both sides raise together and re-request back to back, so grants
    // alternate starting with dcache until one side runs out.
    task automatic run_round(input int ni, input int nd);
        int ii;
        int dd;
        bit turn_d;
        int g;
        ii = 0;
        dd = 0;
        turn_d = 1'b1;
        while (ii < ni || dd < nd) begin
            if (dd < nd && (turn_d || ii >= ni)) begin
                exp_q.push_back('{own_d: 1'b1, wr: (d_ops[dd] != 0), line: d_addrs[dd] & LINE_MASK});
                dd++;
                turn_d = 1'b0;
            end else begin
                exp_q.push_back('{own_d: 1'b0, wr: 1'b0, line: i_addrs[ii] & LINE_MASK});
                ii++;
                turn_d = 1'b1;
            end
        end
        fork
            icache_drv(ni);
            dcache_drv(nd);
        join
        g = $urandom_range(0, 3);
        repeat (g) @(posedge clk);
    endtask

    task automatic fill_random(output int ni, output int nd);
        ni = $urandom_range(0, 2);
        nd = $urandom_range((ni == 0) ? 1 : 0, 2);
        i_addrs.delete();
        d_addrs.delete();
        d_ops.delete();
        for (int k = 0; k < ni; k++) i_addrs.push_back($urandom);
        for (int k = 0; k < nd; k++) begin
            d_addrs.push_back($urandom);
            d_ops.push_back($urandom_range(0, 2));
        end
    endtask

    initial begin
        int t;
        int ni;
        int nd;
        rst = 1'b1;
        bus.icache_read = 1'b0;
        bus.icache_addr = '0;
        bus.dcache_read = 1'b0;
        bus.dcache_write = 1'b0;
        bus.dcache_addr = '0;
        bus.dcache_wdata = '0;
        @(negedge clk);
        chk("reset_outputs", 64'(any_out()), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_outputs", 64'(any_out()), 64'(0));

        // single icache line, memory always ready, back-to-back beats A..D
        rd_cycles = 0;
        i_addrs = '{32'h0000_1234};
        run_round(1, 0);
        chk("icache_read_cmd_cycles", 64'(rd_cycles), 64'(1));

        // dcache write with ready pattern 1,0,1,1,0,1
        wr_cycles = 0;
        wready_cnt = 0;
        d_addrs = '{32'h8000_0040};
        d_ops = '{1};
        arm_pat = 1'b1;
        run_round(0, 1);
        chk("write_cmd_cycles", 64'(wr_cycles), 64'(6));
        chk("write_wready_cycles", 64'(wready_cnt), 64'(4));

        // contention, then sustained contention
        ready_rand = 1'b1;
        rv_always = 1'b0;
        i_addrs = '{32'h0000_2000};
        d_addrs = '{32'h0001_0000};
        d_ops = '{0};
        run_round(1, 1);
        i_addrs = '{32'h0000_3000, 32'h0000_3100};
        d_addrs = '{32'h0002_0000, 32'h0002_0100};
        d_ops = '{0, 1};
        run_round(2, 2);

        // stray rvalid while idle, during writes, then a normal read
        spur_en = 1'b1;
        repeat (10) @(posedge clk);
        d_addrs = '{32'h0003_0020};
        d_ops = '{1};
        run_round(0, 1);
        i_addrs = '{32'h0004_0008};
        run_round(1, 0);

        // read and write together means write only
        rd_cycles = 0;
        d_addrs = '{32'h0005_0000};
        d_ops = '{2};
        run_round(0, 1);
        chk("rw_both_no_read", 64'(rd_cycles), 64'(0));

        // reset in the middle of a read burst
        spur_en = 1'b0;
        ready_rand = 1'b0;
        rv_always = 1'b1;
        exp_q.push_back('{own_d: 1'b0, wr: 1'b0, line: 32'h0006_0040});
        @(posedge clk);
        #1;
        bus.icache_read = 1'b1;
        bus.icache_addr = 32'h0006_0044;
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (!(cur_v && beats >= 2) && t < 200);
        chk("mid_burst_beats_seen", 64'(cur_v && beats >= 2), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.icache_read = 1'b0;
        @(negedge clk);
        chk("mid_burst_reset_outputs", 64'(any_out()), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("after_mid_reset_outputs", 64'(any_out()), 64'(0));
        i_addrs = '{32'h0006_0044};
        run_round(1, 0);

        // randomized traffic
        spur_en = 1'b1;
        ready_rand = 1'b1;
        rv_always = 1'b0;
        repeat (30) begin
            fill_random(ni, nd);
            run_round(ni, nd);
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        chk("no_open_txn", 64'(cur_v), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
